// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the program ROM address from the PC, captures the 32-bit
// little-endian opcode one cycle later and presents its byte fields to execute over a
// valid/ready handshake. Fetch stops for good on HALT; execute may redirect the PC.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   address        byte address to ROM (registered PC, no combinational input path)
//   opcode         ROM data, valid the cycle after address was presented
//   instr_valid    instruction fields below are valid
//   instr_ready    execute accepts on instr_valid & instr_ready at a rising edge
//   instr_op/arg1/arg2/dest  opcode bytes 0..3
//   instr_pc       address the presented instruction was fetched from
//   pc_load        redirect request; pc_target is the new PC (any alignment)
//   halted         HALT fetched; sticky until rst
//   fetch_count    non-HALT instructions captured, wraps at 2^16
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = 8'h32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  address,
  input  logic [31:0] opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_op,
  output logic [7:0]  instr_arg1,
  output logic [7:0]  instr_arg2,
  output logic [7:0]  instr_dest,
  output logic [7:0]  instr_pc,
  input  logic        pc_load,
  input  logic [7:0]  pc_target,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {StIssue, StCapture, StHold, StHalted} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [7:0]  arg2_q, arg2_d;
  logic [7:0]  dest_q, dest_d;
  logic [7:0]  ipc_q, ipc_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q, count_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    op_d     = op_q;
    arg1_d   = arg1_q;
    arg2_d   = arg2_q;
    dest_d   = dest_q;
    ipc_d    = ipc_q;
    halted_d = halted_q;
    count_d  = count_q;

    unique case (state_q)
      StIssue: begin
        if (pc_load) begin
          pc_d    = pc_target;
          state_d = StIssue;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        // A redirect discards the word in flight: no count, no halt.
        if (pc_load) begin
          pc_d    = pc_target;
          state_d = StIssue;
        end else if (opcode[7:0] == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = StHalted;
        end else begin
          op_d    = opcode[7:0];
          arg1_d  = opcode[15:8];
          arg2_d  = opcode[23:16];
          dest_d  = opcode[31:24];
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 8'd4;
          count_d = count_q + 16'd1;
          state_d = StHold;
        end
      end
      StHold: begin
        // With ready and pc_load together the handshake completes and the redirect applies.
        if (pc_load) begin
          pc_d    = pc_target;
          valid_d = 1'b0;
          state_d = StIssue;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = StIssue;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIssue;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIssue;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      op_q     <= 8'h00;
      arg1_q   <= 8'h00;
      arg2_q   <= 8'h00;
      dest_q   <= 8'h00;
      ipc_q    <= 8'h00;
      halted_q <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      arg1_q   <= arg1_d;
      arg2_q   <= arg2_d;
      dest_q   <= dest_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign address     = pc_q;
  assign instr_valid = valid_q;
  assign instr_op    = op_q;
  assign instr_arg1  = arg1_q;
  assign instr_arg2  = arg2_q;
  assign instr_dest  = dest_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: registered ROM model, directed stimulus, and a scoreboard whose
// monitor pops an expected instruction at every valid & ready handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [31:0] opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic [7:0]  instr_arg1;
  logic [7:0]  instr_arg2;
  logic [7:0]  instr_dest;
  logic [7:0]  instr_pc;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        halted;
  logic [15:0] fetch_count;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] dest;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] rom [256];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_arg1  (instr_arg1),
    .instr_arg2  (instr_arg2),
    .instr_dest  (instr_dest),
    .instr_pc    (instr_pc),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // ROM registers the addressed word; byte addresses wrap modulo 256.
  always @(posedge clk) begin
    opcode <= {rom[8'(address + 8'd3)], rom[8'(address + 8'd2)],
               rom[8'(address + 8'd1)], rom[address]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got pc=%0h op=%0h expected none", instr_pc, instr_op);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instr_fields", {24'd0, instr_op, instr_arg1, instr_arg2, instr_dest, instr_pc},
              {24'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] d, input logic [7:0] pc);
    exp_t e;
    e = '{op: op, arg1: a1, arg2: a2, dest: d, pc: pc};
    sb.push_back(e);
  endtask

  // Ends in the first post-reset cycle (ISSUE, address = reset PC).
  task automatic do_reset();
    rst = 1'b1;
    step();
    check("rst_address", 64'(address), 64'h00);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_count", 64'(fetch_count), 64'h0);
    check("rst_fields", {24'd0, instr_op, instr_arg1, instr_arg2, instr_dest, instr_pc}, 64'h0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    {rom[8'h03], rom[8'h02], rom[8'h01], rom[8'h00]} = 32'h1100_0080;
    {rom[8'h07], rom[8'h06], rom[8'h05], rom[8'h04]} = 32'h1420_11C0;
    {rom[8'h0B], rom[8'h0A], rom[8'h09], rom[8'h08]} = 32'h0807_0605;
    {rom[8'h23], rom[8'h22], rom[8'h21], rom[8'h20]} = 32'hCCBB_AA80;
    rom[8'h40] = 8'h32;
    {rom[8'hFF], rom[8'hFE], rom[8'hFD], rom[8'hFC]} = 32'h0403_0201;

    rst         = 1'b1;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 8'h00;

    // Straight-line fetch, ready held high.
    do_reset();
    instr_ready = 1'b1;
    check("c0_address", 64'(address), 64'h00);
    push(8'h80, 8'h00, 8'h00, 8'h11, 8'h00);
    step();
    check("c1_valid", 64'(instr_valid), 64'h0);
    step();
    check("c2_valid", 64'(instr_valid), 64'h1);
    step();
    check("c3_address", 64'(address), 64'h04);
    push(8'hC0, 8'h11, 8'h20, 8'h14, 8'h04);
    step();
    step();
    check("c5_valid", 64'(instr_valid), 64'h1);
    check("c5_count", 64'(fetch_count), 64'h2);
    step();
    check("c6_address", 64'(address), 64'h08);

    // Backpressure: outputs frozen while ready is low.
    instr_ready = 1'b0;
    do_reset();
    push(8'h80, 8'h00, 8'h00, 8'h11, 8'h00);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(instr_valid), 64'h1);
      check("stall_frozen", {instr_op, instr_arg1, instr_arg2, instr_dest, instr_pc, address,
                             fetch_count}, {8'h80, 8'h00, 8'h00, 8'h11, 8'h00, 8'h04, 16'h1});
      step();
    end
    instr_ready = 1'b1;
    step();
    check("post_stall_address", 64'(address), 64'h04);
    instr_ready = 1'b0;

    // Redirect in HOLD with ready low.
    step();
    step();
    check("hold_c0", {55'd0, instr_valid, instr_op}, {55'd0, 1'b1, 8'hC0});
    check("hold_count", 64'(fetch_count), 64'h2);
    pc_load   = 1'b1;
    pc_target = 8'h20;
    step();
    pc_load = 1'b0;
    check("redir_valid", 64'(instr_valid), 64'h0);
    check("redir_address", 64'(address), 64'h20);
    push(8'h80, 8'hAA, 8'hBB, 8'hCC, 8'h20);
    instr_ready = 1'b1;
    step();
    step();
    check("redir_target_valid", 64'(instr_valid), 64'h1);
    check("redir_count", 64'(fetch_count), 64'h3);
    step();
    check("after_20_address", 64'(address), 64'h24);

    // Redirect in ISSUE to 4, then in CAPTURE of 4 away to 8.
    pc_load   = 1'b1;
    pc_target = 8'h04;
    step();
    pc_load = 1'b0;
    check("issue_redir_address", 64'(address), 64'h04);
    step();
    pc_load   = 1'b1;
    pc_target = 8'h08;
    step();
    pc_load = 1'b0;
    check("cap_redir_address", 64'(address), 64'h08);
    check("cap_redir_valid", 64'(instr_valid), 64'h0);
    check("cap_redir_count", 64'(fetch_count), 64'h3);
    push(8'h05, 8'h06, 8'h07, 8'h08, 8'h08);
    step();
    step();
    check("word8_count", 64'(fetch_count), 64'h4);
    step();
    check("after_8_address", 64'(address), 64'h0C);

    // HALT at 40.
    pc_load   = 1'b1;
    pc_target = 8'h40;
    step();
    pc_load = 1'b0;
    check("halt_address", 64'(address), 64'h40);
    step();
    check("halt_not_yet", 64'(halted), 64'h0);
    step();
    check("halted", 64'(halted), 64'h1);
    check("halt_valid", 64'(instr_valid), 64'h0);
    check("halt_count", 64'(fetch_count), 64'h4);
    pc_load   = 1'b1;
    pc_target = 8'h00;
    step();
    pc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt_sticky", {instr_valid, halted, address}, {1'b0, 1'b1, 8'h40});
      step();
    end

    // Reset leaves HALTED; then wrap from FC.
    do_reset();
    pc_load   = 1'b1;
    pc_target = 8'hFC;
    step();
    pc_load = 1'b0;
    check("wrap_address", 64'(address), 64'hFC);
    push(8'h01, 8'h02, 8'h03, 8'h04, 8'hFC);
    step();
    step();
    check("wrap_valid", 64'(instr_valid), 64'h1);
    check("wrap_count", 64'(fetch_count), 64'h1);
    step();
    check("wrap_next_address", 64'(address), 64'h00);

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the program ROM's address/opcode interface. It holds the program counter, drives the byte address to the ROM, and captures the 32-bit little-endian opcode one cycle later. It splits the opcode into its four byte fields and presents them to the execute stage over a valid/ready handshake. It stops fetching on HALT and accepts PC redirects from execute (jumps, conditional branches, CALL/RET, writes to COUNTER).

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OP, 8'h32, opcode byte 0 value that halts fetch
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- address  out  8  byte address to ROM; combinational copy of pc
- opcode  in  32  ROM data, registered in ROM; valid the cycle after address is presented
- instr_valid  out  1  decoded instruction available
- instr_ready  in  1  execute accepts the instruction when instr_valid & instr_ready at a rising edge
- instr_op  out  8  opcode[7:0] (op byte incl. IMM1/IMM2 flags)
- instr_arg1  out  8  opcode[15:8]
- instr_arg2  out  8  opcode[23:16]
- instr_dest  out  8  opcode[31:24]
- instr_pc  out  8  address the presented instruction was fetched from
- pc_load  in  1  redirect request from execute
- pc_target  in  8  redirect address; any byte alignment legal
- halted  out  1  HALT fetched; sticky until rst
- fetch_count  out  16  count of non-HALT instructions captured; wraps at 2^16

## Operation
- State machine: ISSUE -> CAPTURE -> HOLD -> ISSUE; CAPTURE -> HALTED on HALT.
- ISSUE: address = pc. Next state CAPTURE. The ROM samples address at this edge.
- CAPTURE: opcode is valid.
  - If opcode[7:0] == HALT_OP: set halted=1 and go to HALTED. instr_valid is not asserted and fetch_count does not increment.
  - Otherwise: latch the four byte fields and instr_pc=pc, set instr_valid=1, pc <= pc+4 (mod 256), fetch_count += 1, go to HOLD.
- HOLD: all instr_* outputs are stable while instr_valid=1. On handshake (valid & ready), instr_valid <= 0 and go to ISSUE.
- HALTED: terminal state. address stays at the HALT address. Only rst exits.
- pc_load has highest priority in ISSUE, CAPTURE and HOLD:
  - pc <= pc_target, instr_valid <= 0, go to ISSUE.
  - In CAPTURE the opcode is discarded: no count increment and no halt.
  - In HOLD with ready=1 in the same cycle: the handshake completes (execute owns the instruction) and the redirect still applies.
- pc_load is ignored in HALTED.
- PC arithmetic is 8-bit and wraps. The ROM's own address+1..+3 wraps identically.

## Timing
- Reset values: pc=RESET_PC, address=RESET_PC, state=ISSUE, instr_valid=0, instr_op/arg1/arg2/dest=0, instr_pc=0, halted=0, fetch_count=0.
- rst asserted in any state overrides everything at the next edge.
- Fetch latency: instr_valid rises 2 cycles after address is first driven.
- Best-case throughput is one instruction per 3 cycles (ready held high).
- Redirect latency: address = pc_target in the cycle after the pc_load edge. The target's instr_valid follows 2 cycles later.
- halted rises at the edge ending CAPTURE of the HALT word, i.e. 2 edges after address = HALT address.
- No combinational path from instr_ready or pc_load to any output.

## Test plan
- **Straight-line fetch.** ROM[0..3]=80 00 00 11, ROM[4..7]=C0 11 20 14; release rst; ready=1.
  - Cycle 0: address=0. Cycle 2: instr_valid=1, op=80, arg1=00, arg2=00, dest=11, instr_pc=0.
  - Cycle 3: address=4. Cycle 5: op=C0, dest=14, instr_pc=4. fetch_count=2.
- **Backpressure.** Same ROM; ready=0 for 5 cycles after first valid.
  - Outputs are frozen and address stays 4 until ready=1.
  - fetch_count=1 throughout the stall.
- **Redirect in HOLD.** pc_load=1, pc_target=20 while valid and ready=0 (ROM[20]=80).
  - Next cycle: instr_valid=0, address=20.
  - 2 cycles later: instr_pc=20, op=80.
- **Redirect in CAPTURE.** pc_load during CAPTURE of address 4.
  - The word at 4 is never presented and fetch_count is unchanged.
- **HALT.** ROM[40]=32; jump to 40.
  - halted=1 two edges later and instr_valid stays 0.
  - A subsequent pc_load=1, target=0 is ignored: address stays 40.
  - rst then restores address=0, halted=0, fetch_count=0.
- **Wrap.** pc_target=FC with ROM[FC]=01.
  - instr_pc=FC, then the next address is 00.
